// File: rtl/ixu_issue_ctrl.sv
// ixu_issue_ctrl: EX/WB sequencing, rs1/rs2 forwarding and writeback handshake for one IXU slot
module ixu_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_op,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [RADDR_W-1:0] in_rs1,
  input  logic [RADDR_W-1:0] in_rs2,
  input  logic [11:0]        in_imm,
  input  logic               in_is_imm,
  input  logic               in_wen,
  output logic [RADDR_W-1:0] rf_raddr1,
  output logic [RADDR_W-1:0] rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  output logic               ex_is_rs1_fwd,
  output logic               ex_is_rs2_fwd,
  output logic [XLEN-1:0]    ex_rs1_fwd_data,
  output logic [XLEN-1:0]    ex_rs2_fwd_data,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [11:0]        ex_imm,
  output logic               ex_is_imm_type,
  output logic               ex_is_nop,
  output logic [3:0]         ex_op,
  input  logic [XLEN-1:0]    ex_out,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,
  output logic [CNT_W-1:0]   retire_cnt
);
  logic               ex_v, wb_v, ex_is_imm_r, ex_wen, adv, acc, wb_load;
  logic [3:0]         ex_op_r;
  logic [11:0]        ex_imm_r;
  logic [RADDR_W-1:0] ex_rd, ex_rs1, ex_rs2, wb_rd_r;
  logic [XLEN-1:0]    wb_data_r;
  assign adv      = !wb_v || wb_ready;
  assign in_ready = !ex_v || adv;
  assign acc      = in_valid && in_ready;
  assign wb_load  = ex_v && ex_wen && (ex_rd != '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_v        <= 1'b0;
      ex_op_r     <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_imm_r    <= '0;
      ex_is_imm_r <= 1'b0;
      ex_wen      <= 1'b0;
      wb_v        <= 1'b0;
      wb_rd_r     <= '0;
      wb_data_r   <= '0;
      retire_cnt  <= '0;
    end else begin
      if (acc) begin
        ex_v        <= 1'b1;
        ex_op_r     <= in_op;
        ex_rd       <= in_rd;
        ex_rs1      <= in_rs1;
        ex_rs2      <= in_rs2;
        ex_imm_r    <= in_imm;
        ex_is_imm_r <= in_is_imm;
        ex_wen      <= in_wen;
      end else if (adv) begin
        ex_v <= 1'b0;
      end
      if (adv) begin
        wb_v <= wb_load;
        if (wb_load) begin
          wb_rd_r   <= ex_rd;
          wb_data_r <= ex_out;
        end
      end
      if (wb_v && wb_ready) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end
  assign rf_raddr1       = ex_rs1;
  assign rf_raddr2       = ex_rs2;
  assign ex_rs1_data     = rf_rdata1;
  assign ex_rs2_data     = rf_rdata2;
  assign ex_rs1_fwd_data = wb_data_r;
  assign ex_rs2_fwd_data = wb_data_r;
  assign ex_is_rs1_fwd   = ex_v && wb_v && (wb_rd_r == ex_rs1) && (ex_rs1 != '0);
  assign ex_is_rs2_fwd   = ex_v && wb_v && (wb_rd_r == ex_rs2) && (ex_rs2 != '0);
  assign ex_is_nop       = !ex_v;
  assign ex_op           = ex_v ? ex_op_r : '0;
  assign ex_imm          = ex_v ? ex_imm_r : '0;
  assign ex_is_imm_type  = ex_v && ex_is_imm_r;
  assign wb_valid        = wb_v;
  assign wb_rd           = wb_rd_r;
  assign wb_data         = wb_data_r;
endmodule

// File: tb/tb_ixu_issue_ctrl.sv
// tb_ixu_issue_ctrl: vector table, scoreboarded writebacks and corner sequences for ixu_issue_ctrl
module tb_ixu_issue_ctrl;
  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        is_imm, wen;
    logic [31:0] exp;
  } vec_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  logic        clk = 1'b0;
  logic        rst, rf_init, in_valid, in_ready, in_is_imm, in_wen, wb_ready, wb_valid;
  logic [3:0]  in_op, ex_op, cnt4;
  logic [4:0]  in_rd, in_rs1, in_rs2, rf_raddr1, rf_raddr2, wb_rd;
  logic [11:0] in_imm, ex_imm;
  logic [31:0] rf_rdata1, rf_rdata2, ex_rs1_fwd_data, ex_rs2_fwd_data, ex_rs1_data, ex_rs2_data;
  logic [31:0] ex_out, wb_data, retire_cnt, op_a, op_b;
  logic        ex_is_rs1_fwd, ex_is_rs2_fwd, ex_is_imm_type, ex_is_nop;
  logic        u_in_ready, u_fwd1, u_fwd2, u_imm_t, u_nop, u_wb_valid;
  logic [4:0]  u_ra1, u_ra2, u_wb_rd;
  logic [31:0] u_fd1, u_fd2, u_d1, u_d2, u_wb_data;
  logic [11:0] u_imm;
  logic [3:0]  u_op;
  logic [31:0] rf [32];
  logic [31:0] arch [32];
  wb_t         sbq [$];
  vec_t        tv [10];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  ixu_issue_ctrl #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_is_imm(in_is_imm), .in_wen(in_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_is_rs1_fwd(ex_is_rs1_fwd), .ex_is_rs2_fwd(ex_is_rs2_fwd), .ex_rs1_fwd_data(ex_rs1_fwd_data),
    .ex_rs2_fwd_data(ex_rs2_fwd_data), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_is_imm_type(ex_is_imm_type), .ex_is_nop(ex_is_nop), .ex_op(ex_op),
    .ex_out(ex_out), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .retire_cnt(retire_cnt)
  );
  ixu_issue_ctrl #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_is_imm(in_is_imm), .in_wen(in_wen),
    .rf_raddr1(u_ra1), .rf_raddr2(u_ra2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_is_rs1_fwd(u_fwd1), .ex_is_rs2_fwd(u_fwd2), .ex_rs1_fwd_data(u_fd1),
    .ex_rs2_fwd_data(u_fd2), .ex_rs1_data(u_d1), .ex_rs2_data(u_d2),
    .ex_imm(u_imm), .ex_is_imm_type(u_imm_t), .ex_is_nop(u_nop), .ex_op(u_op),
    .ex_out(ex_out), .wb_valid(u_wb_valid), .wb_ready(wb_ready), .wb_rd(u_wb_rd), .wb_data(u_wb_data),
    .retire_cnt(cnt4)
  );
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return op == 4'd0 ? a + b : op == 4'd1 ? a - b : op == 4'd2 ? a & b : op == 4'd3 ? a | b : a ^ b;
  endfunction
  function automatic vec_t mk(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [11:0] imm, input logic is_imm,
                              input logic wen, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.is_imm = is_imm; v.wen = wen; v.exp = exp;
    return v;
  endfunction
  assign op_a      = ex_is_rs1_fwd ? ex_rs1_fwd_data : ex_rs1_data;
  assign op_b      = ex_is_imm_type ? {{20{ex_imm[11]}}, ex_imm} : ex_is_rs2_fwd ? ex_rs2_fwd_data : ex_rs2_data;
  assign ex_out    = ex_is_nop ? 32'd0 : alu(ex_op, op_a, op_b);
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[3] <= 32'h1000;
      rf[4] <= 32'h1000;
      rf[5] <= 32'd5;
    end else if (!rst && wb_valid && wb_ready && wb_rd != 5'd0) begin
      rf[wb_rd] <= wb_data;
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && wb_valid && wb_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected actual=x%0d:%0h required=none", wb_rd, wb_data);
        end else begin
          e = sbq.pop_front();
          chk("wb_rd", wb_rd, e.rd);
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  end
  task automatic drive(input vec_t v, input logic use_exp);
    logic [31:0] r;
    in_valid = 1'b1; in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_imm = v.imm; in_is_imm = v.is_imm; in_wen = v.wen;
    r = use_exp ? v.exp : alu(v.op, arch[v.rs1], v.is_imm ? {{20{v.imm[11]}}, v.imm} : arch[v.rs2]);
    if (v.wen && v.rd != 5'd0) begin
      sbq.push_back({v.rd, r});
      arch[v.rd] = r;
    end
  endtask
  task automatic issue(input vec_t v, input logic use_exp);
    int n = 0;
    drive(v, use_exp);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout actual=in_ready0 required=in_ready1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < 32; i++) arch[i] = rf[i];
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    tv[0] = mk(4'd1, 5'd11, 5'd2,  5'd3,  12'h000, 1'b0, 1'b1, 32'h1080);
    tv[1] = mk(4'd2, 5'd12, 5'd11, 5'd8,  12'h000, 1'b0, 1'b1, 32'h0000);
    tv[2] = mk(4'd3, 5'd13, 5'd11, 5'd5,  12'h000, 1'b0, 1'b1, 32'h1085);
    tv[3] = mk(4'd4, 5'd14, 5'd13, 5'd11, 12'h000, 1'b0, 1'b1, 32'h0005);
    tv[4] = mk(4'd0, 5'd15, 5'd14, 5'd14, 12'hFFA, 1'b1, 1'b1, 32'hFFFF_FFFF);
    tv[5] = mk(4'd0, 5'd0,  5'd15, 5'd15, 12'h000, 1'b0, 1'b1, 32'h0);
    tv[6] = mk(4'd0, 5'd16, 5'd15, 5'd0,  12'h001, 1'b1, 1'b0, 32'h0);
    tv[7] = mk(4'd0, 5'd17, 5'd15, 5'd14, 12'h000, 1'b0, 1'b1, 32'h0004);
    tv[8] = mk(4'd3, 5'd18, 5'd17, 5'd0,  12'h7F0, 1'b1, 1'b1, 32'h07F4);
    tv[9] = mk(4'd1, 5'd19, 5'd18, 5'd15, 12'h000, 1'b0, 1'b1, 32'h07F5);
    for (int i = 0; i < 32; i++) arch[i] = 32'd0;
    arch[3] = 32'h1000; arch[4] = 32'h1000; arch[5] = 32'd5;
    rst = 1'b1; rf_init = 1'b1; wb_ready = 1'b1; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_is_imm = 1'b0; in_wen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rf_init = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_nop", ex_is_nop, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_fwd", {ex_is_rs1_fwd, ex_is_rs2_fwd}, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_ex_op", ex_op, 0);
    chk("rst_wb_data", wb_data, 0);
    issue(mk(4'd0, 5'd1, 5'd3, 5'd4, 12'd0, 1'b0, 1'b1, 0), 1'b0);
    issue(mk(4'd0, 5'd2, 5'd1, 5'd0, 12'd128, 1'b1, 1'b1, 0), 1'b0);
    chk("chain_fwd1", ex_is_rs1_fwd, 1);
    chk("chain_fwd_data", ex_rs1_fwd_data, 32'h2000);
    chk("chain_ex_out", ex_out, 32'h2080);
    idle(3);
    chk("chain_cnt", retire_cnt, 2);
    wb_ready = 1'b0;
    issue(mk(4'd0, 5'd7, 5'd3, 5'd0, 12'd1, 1'b1, 1'b1, 0), 1'b0);
    issue(mk(4'd0, 5'd8, 5'd7, 5'd4, 12'd0, 1'b0, 1'b1, 0), 1'b0);
    drive(mk(4'd1, 5'd9, 5'd8, 5'd3, 12'd0, 1'b0, 1'b1, 0), 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_wb_valid", wb_valid, 1);
      chk("bp_wb_rd", wb_rd, 7);
      chk("bp_wb_data", wb_data, 32'h1001);
      chk("bp_fwd_held", ex_is_rs1_fwd, 1);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    chk("bp_ret0", {wb_valid, wb_rd}, {1'b1, 5'd7});
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_ret1", {wb_valid, wb_rd}, {1'b1, 5'd8});
    @(negedge clk);
    chk("bp_ret2", {wb_valid, wb_rd}, {1'b1, 5'd9});
    @(negedge clk);
    chk("bp_drained", wb_valid, 0);
    do_reset();
    issue(mk(4'd0, 5'd0, 5'd5, 5'd5, 12'd0, 1'b0, 1'b1, 0), 1'b0);
    issue(mk(4'd0, 5'd1, 5'd0, 5'd3, 12'd0, 1'b0, 1'b1, 0), 1'b0);
    chk("x0_no_wb", wb_valid, 0);
    chk("x0_no_fwd", ex_is_rs1_fwd, 0);
    chk("x0_ex_out", ex_out, 32'h1000);
    idle(3);
    chk("x0_cnt", retire_cnt, 1);
    issue(mk(4'd3, 5'd6, 5'd6, 5'd6, 12'd5, 1'b1, 1'b1, 0), 1'b0);
    idle(1);
    chk("bub_nop", ex_is_nop, 1);
    chk("bub_zero", {ex_op, ex_imm, ex_is_imm_type, ex_is_rs1_fwd, ex_is_rs2_fwd}, 0);
    chk("bub_wb_busy", wb_valid, 1);
    idle(1);
    chk("bub_nop2", ex_is_nop, 1);
    chk("bub_wb_idle", wb_valid, 0);
    issue(mk(4'd0, 5'd10, 5'd6, 5'd5, 12'd0, 1'b0, 1'b1, 0), 1'b0);
    idle(3);
    for (int i = 0; i < 10; i++) issue(tv[i], 1'b1);
    idle(4);
    chk("tbl_cnt", retire_cnt, 11);
    chk("tbl_sb_empty", sbq.size(), 0);
    wb_ready = 1'b0;
    issue(mk(4'd0, 5'd20, 5'd3, 5'd0, 12'd7, 1'b1, 1'b1, 0), 1'b0);
    issue(mk(4'd0, 5'd21, 5'd3, 5'd0, 12'd8, 1'b1, 1'b1, 0), 1'b0);
    chk("mid_full", {wb_valid, ex_is_nop}, 2'b10);
    do_reset();
    chk("mid_wb_valid", wb_valid, 0);
    chk("mid_nop", ex_is_nop, 1);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_cnt", retire_cnt, 0);
    wb_ready = 1'b1;
    idle(3);
    chk("mid_no_write", {rf[20], rf[21]}, 0);
    for (int i = 0; i < 17; i++) issue(mk(4'd0, 5'(20 + i % 8), 5'd3, 5'd0, 12'(i), 1'b1, 1'b1, 0), 1'b0);
    idle(4);
    chk("wrap_cnt4", cnt4, 1);
    chk("wrap_cnt32", retire_cnt, 17);
    chk("wrap_sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ixu_issue_ctrl.md
Name: ixu_issue_ctrl

Overview:
- Issue/sequencing controller for one integer execution unit (IXU) slot of the VLIW core.
- Accepts decoded integer ops over a valid/ready handshake and holds them in an EX register that drives the combinational ixu_execute datapath.
- Captures the result into a WB register and retires it to the register file over a second valid/ready handshake.
- Computes the rs1/rs2 forwarding selects and forward data from the WB register, inserts NOPs on bubbles, and back-pressures upstream when writeback stalls.

Parameters:
- XLEN, 32, datapath width; must match ixu_execute.
- RADDR_W, 5, register address width; register 0 is hardwired zero.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  controller can accept an op this cycle
- in_op  in  4  IXU opcode
- in_rd  in  RADDR_W  destination register
- in_rs1  in  RADDR_W  source register 1
- in_rs2  in  RADDR_W  source register 2
- in_imm  in  12  immediate
- in_is_imm  in  1  immediate-type op
- in_wen  in  1  op writes rd
- rf_raddr1  out  RADDR_W  register-file read address 1 (= EX rs1)
- rf_raddr2  out  RADDR_W  register-file read address 2 (= EX rs2)
- rf_rdata1  in  XLEN  combinational read data 1
- rf_rdata2  in  XLEN  combinational read data 2
- ex_is_rs1_fwd  out  1  to ixu_execute
- ex_is_rs2_fwd  out  1  to ixu_execute
- ex_rs1_fwd_data  out  XLEN  to ixu_execute
- ex_rs2_fwd_data  out  XLEN  to ixu_execute
- ex_rs1_data  out  XLEN  to ixu_execute
- ex_rs2_data  out  XLEN  to ixu_execute
- ex_imm  out  12  to ixu_execute
- ex_is_imm_type  out  1  to ixu_execute
- ex_is_nop  out  1  to ixu_execute
- ex_op  out  4  to ixu_execute
- ex_out  in  XLEN  result from ixu_execute
- wb_valid  out  1  writeback request
- wb_ready  in  1  register file accepts writeback
- wb_rd  out  RADDR_W  writeback register
- wb_data  out  XLEN  writeback data
- retire_cnt  out  CNT_W  count of completed writebacks

Behaviour:

Pipeline state
- EX register: ex_v plus op, rd, rs1, rs2, imm, is_imm, wen.
- WB register: wb_v plus rd and data.

Handshake and advance
- adv = !wb_v | wb_ready.
- in_ready = !ex_v | adv. This is combinational, with no dependency on in_valid.
- Accept when in_valid & in_ready: the EX register loads the inputs at the edge.
- If adv and no accept, ex_v is cleared.
- If !adv, the EX register holds.

EX → WB
- On adv & ex_v & ex_wen & (ex_rd != 0): WB loads {ex_rd, ex_out} and wb_v is set.
- On adv otherwise: wb_v is cleared.
- Ops with wen=0 or rd=0 complete in EX with no writeback.

Writeback and counter
- wb_valid = wb_v.
- A writeback completes when wb_valid & wb_ready.
- retire_cnt increments by 1 per completed writeback and wraps modulo 2^CNT_W.

Latency
- Op accepted at edge N is in EX during cycle N+1 (ex_out valid).
- wb_valid is asserted in cycle N+2; the earliest register-file write is at edge N+2.

Datapath drive
- rf_raddr1/2 = EX rs1/rs2.
- ex_rs1_data/ex_rs2_data = rf_rdata1/2 passthrough.
- ex_rs1_fwd_data = ex_rs2_fwd_data = WB data.
- ex_imm, ex_is_imm_type and ex_op come from the EX register.

Forwarding
- ex_is_rs1_fwd = ex_v & wb_v & (wb_rd == ex_rs1) & (ex_rs1 != 0).
- ex_is_rs2_fwd is the same with ex_rs2.
- The register file is written at the WB handshake edge, so one forward source suffices. The op then in EX reads the written value from the register file in the following cycle.
- ex_is_rs2_fwd is computed even when is_imm=1; ixu_execute ignores it.

Bubble
- ex_is_nop = !ex_v.
- When !ex_v: ex_op, ex_imm, ex_is_imm_type and both fwd selects are 0.

Reset
- rst clears ex_v, wb_v and retire_cnt at the next edge.
- Outputs after reset: in_ready=1, ex_is_nop=1, wb_valid=0, fwd selects 0, retire_cnt=0. All other data registers are 0.
- Reset mid-operation discards in-flight ops and drives no writeback.
- rst dominates a simultaneous accept.

Boundary cases
- wb_ready held low: both stages hold and in_ready=0 once EX is full. The EX op keeps forwarding from the held WB value.
- Simultaneous accept, EX→WB move and WB retire in one cycle: fully supported, giving 1 op/cycle throughput.

Test Plan:
- Dependent chain, wb_ready=1:
  - Stimulus: rf x3=0x1000, x4=0x1000; issue add x1,x3,x4; next cycle addi x2,x1,128.
  - Required: second op sees ex_is_rs1_fwd=1 and ex_rs1_fwd_data=0x2000, with ex_out=0x2080.
  - Required: writebacks x1=0x2000 then x2=0x2080; retire_cnt=2.
- Back-pressure:
  - Stimulus: hold wb_ready=0 for 3 cycles with 3 ops offered.
  - Required: in_ready=0 after the EX register fills; wb_valid stays 1 with wb_rd/wb_data stable.
  - Required: after wb_ready=1, all 3 ops retire in order on consecutive cycles.
- x0 handling:
  - Stimulus: add x0 = 5+5, then add x1,x0,x3 with rf x0=0.
  - Required: no writeback for x0 and ex_is_rs1_fwd=0.
  - Required: result equals x3; retire_cnt=1.
- Bubbles:
  - Stimulus: in_valid=0 for 2 cycles between ops.
  - Required: ex_is_nop=1 with op/imm/fwd selects 0 during the gap; wb_valid=0 on the cycles following the bubbles.
- Reset mid-flight:
  - Stimulus: assert rst for 1 cycle while both EX and WB are valid.
  - Required: next cycle wb_valid=0, ex_is_nop=1, in_ready=1, retire_cnt=0; no register-file write occurs.
- Counter wrap:
  - Stimulus: CNT_W=4; complete 17 writebacks.
  - Required: retire_cnt=1.
